histogram_ctrl: RTL and testbench

Sequencing controller for the histogram accumulation RAM.
- Runs each histogram session in order: clear all bins, accumulate incoming samples, then stream every bin out.
- Owns every port of an external simple-dual-port counter RAM (1 read port, 1 write port, 1-cycle registered read).
- Sits between the sample source, the RAM, and a downstream consumer that reads the finished histogram.

---
 rtl/histogram_pkg.sv | 30 +++
 rtl/histogram_ctrl_if.sv | 36 +++
 rtl/histogram_rmw.sv | 57 +++++
 rtl/histogram_ctrl.sv | 128 ++++++++++++
 tb/tb_histogram_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/histogram_pkg.sv
// Shared state encoding, default widths and the bin-counter increment rule
// for the histogram accumulation controller.
package histogram_pkg;

   localparam int unsigned DEF_BIN_W = 8;
   localparam int unsigned DEF_CNT_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ACCUM,
      DRAIN,
      RO_ISSUE,
      RO_HOLD
   } histState_e;

   // A counter at its maximum either holds (saturate) or wraps to zero.
   function automatic logic [31:0] bumpCount(input logic [31:0] oldCount,
                                             input int unsigned cntW,
                                             input logic saturate);
      logic [31:0] maxVal;
      maxVal = (32'd1 << cntW) - 32'd1;
      if (oldCount == maxVal) begin
         bumpCount = saturate ? maxVal : 32'd0;
      end else begin
         bumpCount = oldCount + 32'd1;
      end
   endfunction

endpackage

// File: rtl/histogram_ctrl_if.sv
// Sample, readout, status and RAM signals of the histogram controller.
// The controller connects through slave; the environment through master.
interface histogram_ctrl_if import histogram_pkg::*; #(
   parameter int BIN_W = DEF_BIN_W,
   parameter int CNT_W = DEF_CNT_W
);
   logic             start;
   logic             stop;
   logic             s_valid;
   logic [BIN_W-1:0] s_data;
   logic             s_ready;
   logic             m_valid;
   logic [BIN_W-1:0] m_bin;
   logic [CNT_W-1:0] m_count;
   logic             m_ready;
   logic             busy;
   logic             done;
   logic             overflow;
   logic [BIN_W-1:0] ram_rd_addr;
   logic [CNT_W-1:0] ram_rd_data;
   logic             ram_wr_en;
   logic [BIN_W-1:0] ram_wr_addr;
   logic [CNT_W-1:0] ram_wr_data;

   modport slave (
      input  start, stop, s_valid, s_data, m_ready, ram_rd_data,
      output s_ready, m_valid, m_bin, m_count, busy, done, overflow,
             ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data
   );

   modport master (
      output start, stop, s_valid, s_data, m_ready, ram_rd_data,
      input  s_ready, m_valid, m_bin, m_count, busy, done, overflow,
             ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data
   );
endinterface

// File: rtl/histogram_rmw.sv
// Read-modify-write pipeline for sample accumulation: read on accept, write the
// incremented count one cycle later, forwarding across the RAM's read/write collision.
module histogram_rmw import histogram_pkg::*; #(
   parameter int BIN_W    = DEF_BIN_W,
   parameter int CNT_W    = DEF_CNT_W,
   parameter bit SATURATE = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             accept_i,
   input  logic [BIN_W-1:0] bin_i,
   output logic [BIN_W-1:0] rdAddr_o,
   input  logic [CNT_W-1:0] rdData_i,
   output logic             wrEn_o,
   output logic [BIN_W-1:0] wrAddr_o,
   output logic [CNT_W-1:0] wrData_o,
   output logic             ovf_o
);
   logic             vld_q;
   logic [BIN_W-1:0] bin_q;
   logic             fwd_q;
   logic [CNT_W-1:0] fwdData_q;
   logic             fwd_d;
   logic [CNT_W-1:0] oldCount;
   logic [CNT_W-1:0] newCount;

   // The RAM returns stale data when the bin being written is read in the same
   // cycle, so that read is replaced by the value we just wrote.
   always_comb begin
      fwd_d    = accept_i && vld_q && (bin_i == bin_q);
      oldCount = fwd_q ? fwdData_q : rdData_i;
      newCount = CNT_W'(bumpCount(32'(oldCount), CNT_W, SATURATE));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q     <= 1'b0;
         bin_q     <= '0;
         fwd_q     <= 1'b0;
         fwdData_q <= '0;
      end else begin
         vld_q     <= accept_i;
         fwd_q     <= fwd_d;
         fwdData_q <= newCount;
         if (accept_i) begin
            bin_q <= bin_i;
         end
      end
   end

   assign rdAddr_o = bin_i;
   assign wrEn_o   = vld_q;
   assign wrAddr_o = vld_q ? bin_q : '0;
   assign wrData_o = vld_q ? newCount : '0;
   assign ovf_o    = vld_q && (oldCount == '1);

endmodule

// File: rtl/histogram_ctrl.sv
// Histogram session sequencer: clears every bin, accumulates samples through the
// RMW pipeline, then streams each bin to the consumer with a valid/ready handshake.
module histogram_ctrl import histogram_pkg::*; #(
   parameter int BIN_W    = DEF_BIN_W,
   parameter int CNT_W    = DEF_CNT_W,
   parameter bit SATURATE = 1'b1
) (
   input logic             clk,
   input logic             rst,
   histogram_ctrl_if.slave bus
);
   histState_e       state_q, state_d;
   logic [BIN_W-1:0] clrCnt_q, clrCnt_d;
   logic [BIN_W-1:0] roCnt_q, roCnt_d;
   logic             overflow_q, overflow_d;
   logic             done_q, done_d;
   logic             holdFirst_q;
   logic [CNT_W-1:0] roData_q;
   logic             accept;
   logic [BIN_W-1:0] rmwRdAddr;
   logic             rmwWrEn;
   logic [BIN_W-1:0] rmwWrAddr;
   logic [CNT_W-1:0] rmwWrData;
   logic             rmwOvf;

   histogram_rmw #(.BIN_W(BIN_W), .CNT_W(CNT_W), .SATURATE(SATURATE)) uRmw (
      .clk      (clk),
      .rst      (rst),
      .accept_i (accept),
      .bin_i    (bus.s_data),
      .rdAddr_o (rmwRdAddr),
      .rdData_i (bus.ram_rd_data),
      .wrEn_o   (rmwWrEn),
      .wrAddr_o (rmwWrAddr),
      .wrData_o (rmwWrData),
      .ovf_o    (rmwOvf)
   );

   always_comb begin
      state_d    = state_q;
      clrCnt_d   = clrCnt_q;
      roCnt_d    = roCnt_q;
      overflow_d = overflow_q | rmwOvf;
      done_d     = 1'b0;
      accept     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d    = CLEAR;
               clrCnt_d   = '0;
               overflow_d = 1'b0;
            end
         end
         CLEAR: begin
            clrCnt_d = clrCnt_q + BIN_W'(1);
            if (clrCnt_q == '1) begin
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            accept = bus.s_valid;
            if (bus.stop) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            roCnt_d = '0;
            state_d = RO_ISSUE;
         end
         RO_ISSUE: begin
            state_d = RO_HOLD;
         end
         RO_HOLD: begin
            if (bus.m_ready) begin
               if (roCnt_q == '1) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  roCnt_d = roCnt_q + BIN_W'(1);
                  state_d = RO_ISSUE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The read data is live on the first hold cycle only, so it is latched then
   // and served from the register for as long as the consumer stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         clrCnt_q    <= '0;
         roCnt_q     <= '0;
         overflow_q  <= 1'b0;
         done_q      <= 1'b0;
         holdFirst_q <= 1'b0;
         roData_q    <= '0;
      end else begin
         state_q     <= state_d;
         clrCnt_q    <= clrCnt_d;
         roCnt_q     <= roCnt_d;
         overflow_q  <= overflow_d;
         done_q      <= done_d;
         holdFirst_q <= (state_q == RO_ISSUE);
         if (holdFirst_q) begin
            roData_q <= bus.ram_rd_data;
         end
      end
   end

   assign bus.s_ready     = (state_q == ACCUM);
   assign bus.busy        = (state_q != IDLE);
   assign bus.done        = done_q;
   assign bus.overflow    = overflow_q;
   assign bus.m_valid     = (state_q == RO_HOLD);
   assign bus.m_bin       = (state_q == RO_HOLD) ? roCnt_q : '0;
   assign bus.m_count     = (state_q != RO_HOLD) ? '0 :
                            (holdFirst_q ? bus.ram_rd_data : roData_q);
   assign bus.ram_rd_addr = (state_q == ACCUM) ? rmwRdAddr :
                            ((state_q == RO_ISSUE) || (state_q == RO_HOLD)) ? roCnt_q : '0;
   assign bus.ram_wr_en   = (state_q == CLEAR) || rmwWrEn;
   assign bus.ram_wr_addr = (state_q == CLEAR) ? clrCnt_q : rmwWrAddr;
   assign bus.ram_wr_data = (state_q == CLEAR) ? '0 : rmwWrData;

endmodule

// File: tb/tb_histogram_ctrl.sv
// Bench for histogram_ctrl: a saturating and a wrapping instance run in lockstep,
// each with its own RAM, compared against a plain per-bin sample count.
module tb_histogram_ctrl;
   localparam int BIN_W   = 8;
   localparam int CNT_W   = 8;
   localparam int NBINS   = 256;
   localparam int CNT_MAX = 255;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nCompared = 0;
   int   nMismatch = 0;
   int   refCnt [NBINS];
   logic [CNT_W-1:0] memSat  [NBINS];
   logic [CNT_W-1:0] memWrap [NBINS];

   histogram_ctrl_if #(.BIN_W(BIN_W), .CNT_W(CNT_W)) busSat ();
   histogram_ctrl_if #(.BIN_W(BIN_W), .CNT_W(CNT_W)) busWrap ();

   histogram_ctrl #(.BIN_W(BIN_W), .CNT_W(CNT_W), .SATURATE(1'b1)) dutSat (
      .clk (clk),
      .rst (rst),
      .bus (busSat.slave)
   );

   histogram_ctrl #(.BIN_W(BIN_W), .CNT_W(CNT_W), .SATURATE(1'b0)) dutWrap (
      .clk (clk),
      .rst (rst),
      .bus (busWrap.slave)
   );

   always #5 clk = ~clk;

   // Simple-dual-port RAMs with a registered read that returns old data on collision.
   always @(posedge clk) begin
      if (busSat.ram_wr_en) memSat[busSat.ram_wr_addr] <= busSat.ram_wr_data;
      busSat.ram_rd_data <= memSat[busSat.ram_rd_addr];
      if (busWrap.ram_wr_en) memWrap[busWrap.ram_wr_addr] <= busWrap.ram_wr_data;
      busWrap.ram_rd_data <= memWrap[busWrap.ram_rd_addr];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nCompared++;
      assert (observed === expected) else begin
         nMismatch++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkBoth(input string tag, input logic [31:0] obsSat,
                            input logic [31:0] obsWrap, input logic [31:0] expected);
      checkOutput({tag, "_sat"}, obsSat, expected);
      checkOutput({tag, "_wrap"}, obsWrap, expected);
   endtask

   task automatic waitEdge();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic startV, input logic stopV, input logic sValid,
                                input logic [BIN_W-1:0] sData, input logic mReady);
      busSat.start    = startV;
      busSat.stop     = stopV;
      busSat.s_valid  = sValid;
      busSat.s_data   = sData;
      busSat.m_ready  = mReady;
      busWrap.start   = startV;
      busWrap.stop    = stopV;
      busWrap.s_valid = sValid;
      busWrap.s_data  = sData;
      busWrap.m_ready = mReady;
      #1;
   endtask

   task automatic modelReset();
      for (int i = 0; i < NBINS; i++) refCnt[i] = 0;
   endtask

   function automatic logic [31:0] expCount(input int bin, input bit sat);
      if (sat) return (refCnt[bin] > CNT_MAX) ? CNT_MAX : refCnt[bin];
      return refCnt[bin] % (CNT_MAX + 1);
   endfunction

   function automatic logic [31:0] expOverflow();
      for (int i = 0; i < NBINS; i++) if (refCnt[i] > CNT_MAX) return 1;
      return 0;
   endfunction

   task automatic checkIdleOutputs(input string pfx);
      checkBoth({pfx, "_busy"},   32'(busSat.busy),        32'(busWrap.busy),        0);
      checkBoth({pfx, "_done"},   32'(busSat.done),        32'(busWrap.done),        0);
      checkBoth({pfx, "_ovf"},    32'(busSat.overflow),    32'(busWrap.overflow),    0);
      checkBoth({pfx, "_sready"}, 32'(busSat.s_ready),     32'(busWrap.s_ready),     0);
      checkBoth({pfx, "_mvalid"}, 32'(busSat.m_valid),     32'(busWrap.m_valid),     0);
      checkBoth({pfx, "_mbin"},   32'(busSat.m_bin),       32'(busWrap.m_bin),       0);
      checkBoth({pfx, "_mcount"}, 32'(busSat.m_count),     32'(busWrap.m_count),     0);
      checkBoth({pfx, "_we"},     32'(busSat.ram_wr_en),   32'(busWrap.ram_wr_en),   0);
      checkBoth({pfx, "_waddr"},  32'(busSat.ram_wr_addr), 32'(busWrap.ram_wr_addr), 0);
      checkBoth({pfx, "_wdata"},  32'(busSat.ram_wr_data), 32'(busWrap.ram_wr_data), 0);
      checkBoth({pfx, "_raddr"},  32'(busSat.ram_rd_addr), 32'(busWrap.ram_rd_addr), 0);
   endtask

   // Pulses start from IDLE and walks the clear phase; leaves the bench in ACCUM.
   task automatic runClear(input bit checkEach);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      checkBoth("pre_start_busy", 32'(busSat.busy), 32'(busWrap.busy), 0);
      waitEdge();
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      checkBoth("start_busy", 32'(busSat.busy), 32'(busWrap.busy), 1);
      checkBoth("start_ovf_clr", 32'(busSat.overflow), 32'(busWrap.overflow), 0);
      for (int i = 0; i < NBINS; i++) begin
         if (checkEach) begin
            checkBoth("clr_we",     32'(busSat.ram_wr_en),   32'(busWrap.ram_wr_en),   1);
            checkBoth("clr_addr",   32'(busSat.ram_wr_addr), 32'(busWrap.ram_wr_addr), i);
            checkBoth("clr_data",   32'(busSat.ram_wr_data), 32'(busWrap.ram_wr_data), 0);
            checkBoth("clr_sready", 32'(busSat.s_ready),     32'(busWrap.s_ready),     0);
         end
         waitEdge();
      end
      checkBoth("accum_sready", 32'(busSat.s_ready), 32'(busWrap.s_ready), 1);
      checkBoth("accum_we_idle", 32'(busSat.ram_wr_en), 32'(busWrap.ram_wr_en), 0);
   endtask

   task automatic sendSample(input logic sValid, input logic [BIN_W-1:0] sData,
                             input logic stopV);
      applyStimulus(1'b0, stopV, sValid, sData, 1'b0);
      checkBoth("sample_sready", 32'(busSat.s_ready), 32'(busWrap.s_ready), 1);
      if (sValid) refCnt[sData]++;
      waitEdge();
   endtask

   // Consumes every bin in order; with backpressure m_ready follows 0,0,1 per bin.
   task automatic readoutAll(input bit backpressure);
      int waitCycles;
      for (int b = 0; b < NBINS; b++) begin
         waitCycles = 0;
         applyStimulus(1'b0, 1'b0, 1'b0, '0, !backpressure);
         while (busSat.m_valid !== 1'b1 && waitCycles < 8) begin
            checkBoth("ro_done_low", 32'(busSat.done), 32'(busWrap.done), 0);
            waitEdge();
            waitCycles++;
         end
         checkBoth("ro_valid", 32'(busSat.m_valid), 32'(busWrap.m_valid), 1);
         if (busSat.m_valid !== 1'b1) break;
         for (int k = 0; k < 3; k++) begin
            if (k > 0 && !backpressure) break;
            if (k == 2) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
            checkBoth("ro_hold_valid", 32'(busSat.m_valid), 32'(busWrap.m_valid), 1);
            checkBoth("ro_bin", 32'(busSat.m_bin), 32'(busWrap.m_bin), b);
            checkOutput("ro_count_sat",  32'(busSat.m_count),  expCount(b, 1'b1));
            checkOutput("ro_count_wrap", 32'(busWrap.m_count), expCount(b, 1'b0));
            if (k < 2 && backpressure) waitEdge();
         end
         waitEdge();
         if (b == NBINS - 1) begin
            checkBoth("done_pulse", 32'(busSat.done), 32'(busWrap.done), 1);
            checkBoth("end_busy", 32'(busSat.busy), 32'(busWrap.busy), 0);
         end else begin
            checkBoth("done_early", 32'(busSat.done), 32'(busWrap.done), 0);
         end
      end
      waitEdge();
      checkBoth("done_once", 32'(busSat.done), 32'(busWrap.done), 0);
   endtask

   initial begin
      logic [BIN_W-1:0] d;
      logic             v;
      int               sevens;
      int               guard;

      // Reset values
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      waitEdge();
      waitEdge();
      checkIdleOutputs("reset");
      rst = 1'b0;
      waitEdge();
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
      waitEdge();
      checkBoth("idle_stop_ignored", 32'(busSat.busy), 32'(busWrap.busy), 0);

      // Back-to-back same bin, then a sample colliding with stop
      $display("[TB] session: back-to-back and stop collision");
      modelReset();
      runClear(1'b1);
      for (int i = 0; i < 5; i++) sendSample(1'b1, 8'd5, 1'b0);
      sendSample(1'b1, 8'd9, 1'b0);
      sendSample(1'b1, 8'd3, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'd4, 1'b0);
      checkBoth("post_stop_sready", 32'(busSat.s_ready), 32'(busWrap.s_ready), 0);
      waitEdge();
      readoutAll(1'b0);
      checkBoth("s1_ovf", 32'(busSat.overflow), 32'(busWrap.overflow), expOverflow());

      // 300 hits on bin 7 mixed with random traffic, read out under backpressure
      $display("[TB] session: saturation/wrap with backpressure");
      modelReset();
      runClear(1'b0);
      sevens = 0;
      guard  = 0;
      while (sevens < 300 && guard < 2000) begin
         if ($urandom_range(1, 0) != 0) begin
            d = 8'd7;
            v = 1'b1;
            sevens++;
         end else begin
            d = 8'($urandom_range(15, 0));
            if (d == 8'd7) d = 8'd8;
            v = ($urandom_range(3, 0) != 0);
         end
         sendSample(v, d, 1'b0);
         guard++;
      end
      sendSample(1'b0, '0, 1'b1);
      readoutAll(1'b1);
      checkBoth("s2_ovf", 32'(busSat.overflow), 32'(busWrap.overflow), expOverflow());

      // Reset while clearing address 100
      $display("[TB] session: reset during clear");
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      waitEdge();
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      repeat (100) waitEdge();
      checkBoth("clr_addr100", 32'(busSat.ram_wr_addr), 32'(busWrap.ram_wr_addr), 100);
      rst = 1'b1;
      #1;
      checkIdleOutputs("rst_clear");
      waitEdge();
      rst = 1'b0;

      // Full clear after the abort, then reset while holding the first bin
      $display("[TB] session: reset during readout hold");
      modelReset();
      runClear(1'b1);
      for (int i = 0; i < 20; i++) sendSample(1'b1, 8'($urandom()), 1'b0);
      sendSample(1'b0, '0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      waitEdge();
      waitEdge();
      checkBoth("hold_valid", 32'(busSat.m_valid), 32'(busWrap.m_valid), 1);
      checkOutput("hold_count_sat", 32'(busSat.m_count), expCount(0, 1'b1));
      waitEdge();
      rst = 1'b1;
      #1;
      checkIdleOutputs("rst_hold");
      waitEdge();
      rst = 1'b0;

      // Clean session after the abort, dense hazards on a few bins
      $display("[TB] session: recovery with dense hazards");
      modelReset();
      runClear(1'b1);
      for (int i = 0; i < 40; i++) begin
         v = 1'($urandom_range(1, 0));
         d = 8'($urandom_range(3, 0));
         sendSample(v, d, 1'b0);
      end
      sendSample(1'b0, '0, 1'b1);
      readoutAll(1'b0);
      checkBoth("s5_ovf", 32'(busSat.overflow), 32'(busWrap.overflow), expOverflow());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
